// File: rtl/datapath_pkg.sv
// Shared definitions for the 4-bit, four-register datapath.
//   DATA_W   : register / ALU data width
//   NUM_REGS : number of registers in the file
//   ADDR_W   : register address width
//   alu_op_e : ALU operation encodings
package datapath_pkg;

  localparam int DATA_W   = 4;
  localparam int NUM_REGS = 4;
  localparam int ADDR_W   = 2;

  typedef enum logic [2:0] {
    OP_ZERO  = 3'b000,
    OP_ONE   = 3'b001,
    OP_INC   = 3'b010,
    OP_DEC   = 3'b011,
    OP_LOAD  = 3'b100,
    OP_PASSA = 3'b101,
    OP_ADD   = 3'b110,
    OP_PASSB = 3'b111
  } alu_op_e;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU for the datapath. All arithmetic wraps modulo 2**DATA_W;
// carry and borrow are dropped.
// Ports:
//   a, b    : operands (A from read port 2, B from read port 1)
//   count   : immediate value passed through by OP_LOAD
//   opcode  : operation select (alu_op_e encoding)
//   f       : result
//   zero    : high when f is all zeros
module alu
  import datapath_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] count,
  input  logic [2:0]        opcode,
  output logic [DATA_W-1:0] f,
  output logic              zero
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  always_comb begin
    f = '0;
    case (alu_op_e'(opcode))
      OP_ZERO:  f = '0;
      OP_ONE:   f = ONE;
      OP_INC:   f = a + ONE;
      OP_DEC:   f = a - ONE;
      OP_LOAD:  f = count;
      OP_PASSA: f = a;
      OP_ADD:   f = a + b;
      OP_PASSB: f = b;
      default:  f = '0;
    endcase
  end

  assign zero = (f == '0);

endmodule

// File: rtl/datapath.sv
// Four-entry, 4-bit register file with a combinational ALU, sequenced cycle
// by cycle by an external controller.
// Ports:
//   Clk        : clock, all register updates on the rising edge
//   Rst        : synchronous active-high reset, clears R0..R3 (beats writes)
//   wrt_addr   : register written when wrt_en is high
//   wrt_en     : write enable
//   load_data  : write source, 1 = count, 0 = ALU result
//   rd_addr1   : read port 1 address (ALU operand B)
//   rd_addr2   : read port 2 address (ALU operand A)
//   alu_opcode : ALU operation
//   count      : controller immediate value
//   data       : ALU result, combinational
//   zero_flag  : high when data is zero, combinational
module datapath
  import datapath_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] wrt_addr,
  input  logic              wrt_en,
  input  logic              load_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] data,
  output logic              zero_flag
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0]   opnd_a;
  logic [DATA_W-1:0]   opnd_b;
  logic [DATA_W-1:0]   alu_f;
  logic [DATA_W-1:0]   wr_data;

  // One-hot write decode, all zeros when writes are disabled.
  always_comb begin
    wr_sel = '0;
    if (wrt_en) wr_sel[wrt_addr] = 1'b1;
  end

  // Asynchronous reads: a same-cycle write is not bypassed, so a read of the
  // register being written returns its pre-edge value.
  assign opnd_a = regs[rd_addr2];
  assign opnd_b = regs[rd_addr1];

  alu u_alu (
    .a      (opnd_a),
    .b      (opnd_b),
    .count  (count),
    .opcode (alu_opcode),
    .f      (alu_f),
    .zero   (zero_flag)
  );

  assign data = alu_f;

  // The write mux feeds only register D inputs, so no combinational loop
  // forms through the read muxes and ALU.
  assign wr_data = load_data ? count : alu_f;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    always_ff @(posedge Clk) begin
      if (Rst)             regs[gi] <= '0;
      else if (wr_sel[gi]) regs[gi] <= wr_data;
    end
  end

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [1:0] wrt_addr;
  logic       wrt_en;
  logic       load_data;
  logic [1:0] rd_addr1;
  logic [1:0] rd_addr2;
  logic [2:0] alu_opcode;
  logic [3:0] count;
  logic [3:0] data;
  logic       zero_flag;

  datapath dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .wrt_addr   (wrt_addr),
    .wrt_en     (wrt_en),
    .load_data  (load_data),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .alu_opcode (alu_opcode),
    .count      (count),
    .data       (data),
    .zero_flag  (zero_flag)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [3:0] d;
    logic       z;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  logic chk_vld = 1'b0;

  // Monitor: pops one expectation whenever a check is presented.
  always @(negedge Clk) begin
    if (chk_vld) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL scoreboard_empty: data=%0d zf=%0b with nothing expected", data, zero_flag);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (data !== e.d || zero_flag !== e.z) begin
          failed++;
          $display("FAIL %s: got data=%0d zf=%0b, expected data=%0d zf=%0b",
                   e.name, data, zero_flag, e.d, e.z);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string n, input logic [3:0] d);
    exp_t e;
    e.name = n;
    e.d    = d;
    e.z    = (d == 4'd0);
    exp_q.push_back(e);
    chk_vld = 1'b1;
    @(negedge Clk);
    #1;
    chk_vld = 1'b0;
  endtask

  task automatic load(input logic [1:0] a, input logic [3:0] v);
    wrt_addr  = a;
    count     = v;
    load_data = 1'b1;
    wrt_en    = 1'b1;
    step();
    wrt_en    = 1'b0;
    load_data = 1'b0;
  endtask

  // Write the ALU result of (op, A=R[ra2], B=R[ra1]) into R[wa].
  task automatic alu_wr(input logic [1:0] wa, input logic [2:0] op,
                        input logic [1:0] ra2, input logic [1:0] ra1);
    wrt_addr   = wa;
    alu_opcode = op;
    rd_addr2   = ra2;
    rd_addr1   = ra1;
    load_data  = 1'b0;
    wrt_en     = 1'b1;
    step();
    wrt_en     = 1'b0;
  endtask

  task automatic read_a(input logic [1:0] ra2);
    rd_addr2   = ra2;
    alu_opcode = 3'b101;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [3:0] sweep_exp [8];
  logic [3:0] fib_exp   [7];
  logic [3:0] pre_vals  [4];

  initial begin
    sweep_exp = '{4'h0, 4'h1, 4'h0, 4'hE, 4'hA, 4'hF, 4'h2, 4'h3};
    fib_exp   = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13, 4'd5};
    pre_vals  = '{4'd5, 4'd6, 4'd7, 4'd8};

    Rst = 1'b1; wrt_addr = 2'd0; wrt_en = 1'b0; load_data = 1'b0;
    rd_addr1 = 2'd0; rd_addr2 = 2'd0; alu_opcode = 3'b000; count = 4'd0;
    step();
    step();
    Rst = 1'b0;

    // Post-reset outputs depend only on opcode and zeroed registers.
    alu_opcode = 3'b000; check("post_reset_op000", 4'd0);
    alu_opcode = 3'b001; check("post_reset_op001", 4'd1);

    // Reset clears preloaded registers.
    for (int i = 0; i < 4; i++) load(2'(i), pre_vals[i]);
    read_a(2'd3);
    check("preload_r3", 4'd8);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read_a(2'(i));
      check($sformatf("reset_r%0d", i), 4'd0);
    end

    // Load path, then a held count with writes disabled.
    load(2'd2, 4'd9);
    read_a(2'd2);
    check("load_r2", 4'd9);
    count = 4'd3;
    step();
    check("hold_r2", 4'd9);

    // ALU sweep with A=R0=F, B=R1=3, count=A.
    load(2'd0, 4'hF);
    load(2'd1, 4'h3);
    rd_addr2 = 2'd0;
    rd_addr1 = 2'd1;
    count    = 4'hA;
    for (int op = 0; op < 8; op++) begin
      alu_opcode = 3'(op);
      check($sformatf("alu_op%0d", op), sweep_exp[op]);
    end

    // Fibonacci loop.
    load(2'd0, 4'd1);
    load(2'd1, 4'd0);
    for (int it = 0; it < 7; it++) begin
      alu_wr(2'd2, 3'b101, 2'd0, 2'd0);
      alu_wr(2'd0, 3'b110, 2'd0, 2'd1);
      alu_wr(2'd1, 3'b101, 2'd2, 2'd0);
      read_a(2'd0);
      check($sformatf("fib_iter%0d", it), fib_exp[it]);
    end

    // Read-during-write returns the old value until the edge.
    load(2'd3, 4'd4);
    wrt_addr = 2'd3; count = 4'd7; load_data = 1'b1; wrt_en = 1'b1;
    read_a(2'd3);
    check("rdw_before", 4'd4);
    step();
    wrt_en = 1'b0; load_data = 1'b0;
    check("rdw_after", 4'd7);

    // Reset wins over a simultaneous write.
    load(2'd1, 4'd2);
    Rst = 1'b1; wrt_en = 1'b1; load_data = 1'b1; count = 4'd6; wrt_addr = 2'd1;
    step();
    Rst = 1'b0; wrt_en = 1'b0; load_data = 1'b0;
    alu_opcode = 3'b111; rd_addr1 = 2'd1;
    check("rst_vs_write_r1", 4'd0);

    @(negedge Clk);
    #2;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
